// File: rtl/boot_fetch_bridge.sv
// Boot fetch bridge: turns one 16-byte line fetch from the core into two
// 8-byte boot-ROM reads, with timeout, kill and drain handling.
module boot_fetch_bridge #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req_valid_i,
  input  logic [23:0]  req_addr_i,
  output logic         req_ready_o,
  input  logic         kill_i,
  output logic         resp_valid_o,
  output logic [127:0] resp_data_o,
  output logic         resp_err_o,
  input  logic         resp_ready_i,
  output logic [23:0]  brom_req_address_o,
  output logic         brom_req_valid_o,
  input  logic         brom_ready_i,
  input  logic [127:0] brom_resp_data_i,
  input  logic         brom_resp_valid_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, RESP, DRAIN
  } state_t;

  state_t           state_reg, state_next;
  logic [19:0]      line_reg, line_next;
  logic [127:0]     data_reg, data_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout;
  logic             unused_rom_hi;

  // The ROM returns 8 bytes per read; the upper half of its bus carries nothing useful.
  assign unused_rom_hi = ^brom_resp_data_i[127:64];
  assign timeout       = (cnt_reg == CNT_LAST);
  assign resp_data_o   = data_reg;
  assign resp_err_o    = err_reg;

  always_comb begin
    state_next         = state_reg;
    line_next          = line_reg;
    data_next          = data_reg;
    err_next           = err_reg;
    cnt_next           = cnt_reg;
    req_ready_o        = 1'b0;
    resp_valid_o       = 1'b0;
    brom_req_valid_o   = 1'b0;
    brom_req_address_o = {line_reg, 4'h0};
    case (state_reg)
      IDLE: begin
        req_ready_o = rstn;
        if (req_valid_i) begin
          line_next  = req_addr_i[23:4];
          err_next   = 1'b0;
          state_next = REQ_LO;
        end
      end
      REQ_LO, REQ_HI: begin
        // The strobe follows brom_ready_i directly, so a kill in the same cycle
        // cannot retract it and the in-flight read has to be drained.
        brom_req_address_o = {line_reg, (state_reg == REQ_HI) ? 4'h8 : 4'h0};
        brom_req_valid_o   = brom_ready_i;
        cnt_next           = '0;
        if (kill_i)
          state_next = brom_ready_i ? DRAIN : IDLE;
        else if (brom_ready_i)
          state_next = (state_reg == REQ_LO) ? WAIT_LO : WAIT_HI;
      end
      WAIT_LO, WAIT_HI: begin
        cnt_next = cnt_reg + 1'b1;
        if (kill_i) begin
          cnt_next   = '0;
          state_next = brom_resp_valid_i ? IDLE : DRAIN;
        end else if (brom_resp_valid_i) begin
          if (state_reg == WAIT_LO) begin
            data_next[63:0] = brom_resp_data_i[63:0];
            state_next      = REQ_HI;
          end else begin
            data_next[127:64] = brom_resp_data_i[63:0];
            state_next        = RESP;
          end
        end else if (timeout) begin
          data_next  = '0;
          err_next   = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (kill_i || resp_ready_i)
          state_next = IDLE;
      end
      DRAIN: begin
        // Counter restarts on entry so a lost response cannot wedge the bridge.
        cnt_next = cnt_reg + 1'b1;
        if (brom_resp_valid_i || timeout)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      line_reg  <= '0;
      data_reg  <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      line_reg  <= line_next;
      data_reg  <= data_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_boot_fetch_bridge.sv
// Randomized self-checking bench for boot_fetch_bridge: a transaction-level
// ROM model and scoreboard plus directed kill/reset/backpressure scenarios.
module tb_boot_fetch_bridge;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req_valid_i;
  logic [23:0]  req_addr_i;
  logic         req_ready_o;
  logic         kill_i;
  logic         resp_valid_o;
  logic [127:0] resp_data_o;
  logic         resp_err_o;
  logic         resp_ready_i;
  logic [23:0]  brom_req_address_o;
  logic         brom_req_valid_o;
  logic         brom_ready_i;
  logic [127:0] brom_resp_data_i;
  logic         brom_resp_valid_i;

  always #5 clk = ~clk;

  boot_fetch_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
    .kill_i(kill_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .resp_ready_i(resp_ready_i),
    .brom_req_address_o(brom_req_address_o), .brom_req_valid_o(brom_req_valid_o),
    .brom_ready_i(brom_ready_i), .brom_resp_data_i(brom_resp_data_i),
    .brom_resp_valid_i(brom_resp_valid_i)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // next-cycle input values, applied at the falling edge by step()
  logic        nx_rstn = 1'b0, nx_req_valid = 1'b0, nx_kill = 1'b0, nx_resp_ready = 1'b0;
  logic [23:0] nx_addr = '0;
  bit          nx_hold = 0, nx_spur = 0;

  // ROM model state
  bit          rom_fixed = 0, rom_pending = 0;
  int          rom_delay = 0, rom_drop = 0, rom_lat_max = 3, n_strobe = 0;
  logic [23:0] rom_addr = '0;

  logic [23:0] strobe_q[$];
  int          last_strobe_cyc = 0;
  bit          prev_strobe = 0;
  logic        s_req_ready, s_resp_valid, s_resp_err, s_strobe;
  logic [127:0] s_resp_data;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rom_word(input logic [23:0] a);
    if (rom_fixed) return a[3] ? {16{4'h2}} : {16{4'h1}};
    return {a, 8'hA5, ~a, 8'h3C};
  endfunction

  // One clock cycle: drive at the falling edge, sample 2ns later (well before the rising edge).
  task automatic step();
    @(negedge clk);
    rstn         = nx_rstn;
    req_valid_i  = nx_req_valid;
    req_addr_i   = nx_addr;
    kill_i       = nx_kill;
    resp_ready_i = nx_resp_ready;
    brom_resp_valid_i = 1'b0;
    brom_resp_data_i  = {$urandom, $urandom, $urandom, $urandom};
    if (nx_spur) begin
      brom_resp_valid_i = 1'b1;
    end else if (rom_pending) begin
      if (rom_delay == 0) begin
        brom_resp_valid_i      = 1'b1;
        brom_resp_data_i[63:0] = rom_word(rom_addr);
        rom_pending            = 0;
      end else begin
        rom_delay--;
      end
    end
    brom_ready_i = !rom_pending && !nx_hold;
    #2;
    s_req_ready  = req_ready_o;
    s_resp_valid = resp_valid_o;
    s_resp_err   = resp_err_o;
    s_resp_data  = resp_data_o;
    s_strobe     = brom_req_valid_o;
    if (s_strobe) begin
      check("strobe_when_ready", 128'(brom_ready_i), 128'(1));
      check("strobe_not_back_to_back", 128'(prev_strobe), 128'(0));
      strobe_q.push_back(brom_req_address_o);
      n_strobe++;
      last_strobe_cyc = cyc;
      if (n_strobe != rom_drop) begin
        rom_pending = 1;
        rom_addr    = brom_req_address_o;
        rom_delay   = int'($urandom_range(rom_lat_max));
      end
    end
    if (s_resp_valid) check("no_ready_in_resp", 128'(s_req_ready), 128'(0));
    prev_strobe = s_strobe;
    cyc++;
  endtask

  task automatic start(input logic [23:0] addr, input int drop);
    strobe_q.delete();
    n_strobe     = 0;
    rom_drop     = drop;
    nx_req_valid = 1'b1;
    nx_addr      = addr;
    step();
    check("accept", 128'(s_req_ready), 128'(1));
    nx_req_valid = 1'b0;
    nx_addr      = 24'($urandom);
  endtask

  task automatic wait_resp();
    bit got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      step();
      got = s_resp_valid;
    end
    check("resp_seen", 128'(got), 128'(1));
  endtask

  // Full fetch; drop=1/2 makes the ROM ignore the low/high read to force a timeout.
  task automatic fetch(input logic [23:0] addr, input int drop, input int hold_rdy, input int hold_resp);
    logic [19:0]  line;
    logic [127:0] exp_data;
    logic         exp_err;
    line = addr[23:4];
    start(addr, drop);
    if (hold_rdy > 0) begin
      nx_hold = 1;
      repeat (hold_rdy) step();
      nx_hold = 0;
      check("no_strobe_while_busy", 128'(strobe_q.size()), 128'(0));
      step();
      check("strobe_on_ready", 128'(strobe_q.size()), 128'(1));
    end
    wait_resp();
    exp_err  = (drop != 0);
    exp_data = exp_err ? 128'(0) : {rom_word({line, 4'h8}), rom_word({line, 4'h0})};
    check("resp_err", 128'(s_resp_err), 128'(exp_err));
    check("resp_data", s_resp_data, exp_data);
    check("strobe_count", 128'(strobe_q.size()), 128'((drop == 1) ? 1 : 2));
    if (strobe_q.size() > 0) check("addr_lo", 128'(strobe_q[0]), 128'({line, 4'h0}));
    if (strobe_q.size() > 1) check("addr_hi", 128'(strobe_q[1]), 128'({line, 4'h8}));
    if (exp_err) check("timeout_latency", 128'(cyc - 1 - last_strobe_cyc), 128'(TO + 1));
    for (int i = 0; i < hold_resp; i++) begin
      step();
      check("hold_valid", 128'(s_resp_valid), 128'(1));
      check("hold_data", s_resp_data, exp_data);
      check("hold_busy", 128'(s_req_ready), 128'(0));
    end
    nx_resp_ready = 1'b1;
    step();
    check("handshake_valid", 128'(s_resp_valid), 128'(1));
    nx_resp_ready = 1'b0;
    step();
    check("idle_after_resp", 128'(s_req_ready), 128'(1));
    check("valid_dropped", 128'(s_resp_valid), 128'(0));
    $display("fetch addr=%h drop=%0d hold_rdy=%0d hold_resp=%0d err=%0d data=%h",
             addr, drop, hold_rdy, hold_resp, exp_err, exp_data);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit saw_valid;
    rstn = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; kill_i = 1'b0; resp_ready_i = 1'b0;
    brom_ready_i = 1'b0; brom_resp_data_i = '0; brom_resp_valid_i = 1'b0;

    step(); step();
    check("rst_req_ready", 128'(s_req_ready), 128'(0));
    check("rst_resp_valid", 128'(s_resp_valid), 128'(0));
    check("rst_resp_err", 128'(s_resp_err), 128'(0));
    check("rst_strobe", 128'(s_strobe), 128'(0));
    check("rst_data", s_resp_data, 128'(0));
    nx_rstn = 1'b1;
    step();
    check("post_rst_ready", 128'(s_req_ready), 128'(1));

    // line fetch with known ROM words
    rom_fixed = 1;
    fetch(24'h000104, 0, 0, 0);
    rom_fixed = 0;
    // ROM busy for 10 cycles after accept
    fetch(24'($urandom), 0, 10, 0);
    // no ROM response at all
    fetch(24'($urandom), 1, 0, 0);
    // core back-pressure in RESP
    fetch(24'($urandom), 0, 0, 5);

    // kill in WAIT_HI; ROM answers two cycles later
    rom_lat_max = 0;
    start(24'h00ABC7, 2);
    for (int i = 0; i < 50 && strobe_q.size() < 2; i++) step();
    check("kill_hi_reached", 128'(strobe_q.size()), 128'(2));
    rom_pending = 1; rom_addr = strobe_q[1]; rom_delay = 2;
    saw_valid = 0;
    nx_kill = 1'b1; step(); nx_kill = 1'b0;
    saw_valid |= s_resp_valid;
    step(); saw_valid |= s_resp_valid;
    check("drain_busy", 128'(s_req_ready), 128'(0));
    step(); saw_valid |= s_resp_valid;
    check("drain_resp_cycle", 128'(s_req_ready), 128'(0));
    check("drain_resp_seen", 128'(brom_resp_valid_i), 128'(1));
    step(); saw_valid |= s_resp_valid;
    check("ready_after_drain", 128'(s_req_ready), 128'(1));
    check("kill_no_resp", 128'(saw_valid), 128'(0));
    check("kill_strobes", 128'(strobe_q.size()), 128'(2));
    $display("kill in WAIT_HI line=%h", strobe_q[0]);
    rom_lat_max = 3;

    // kill in REQ_LO while ROM busy: no strobe, straight back to IDLE
    start(24'h0F0F00, 0);
    nx_hold = 1;
    step();
    nx_kill = 1'b1; step(); nx_kill = 1'b0; nx_hold = 0;
    step();
    check("kill_req_idle", 128'(s_req_ready), 128'(1));
    check("kill_req_no_strobe", 128'(strobe_q.size()), 128'(0));
    $display("kill in REQ_LO addr=0f0f00");

    // kill in RESP drops the response
    start(24'($urandom), 0);
    wait_resp();
    nx_kill = 1'b1; step(); nx_kill = 1'b0;
    step();
    check("kill_resp_idle", 128'(s_req_ready), 128'(1));
    check("kill_resp_valid", 128'(s_resp_valid), 128'(0));
    $display("kill in RESP");

    // reset in WAIT_LO, stray ROM response one cycle after release
    start(24'h012345, 1);
    for (int i = 0; i < 20 && strobe_q.size() < 1; i++) step();
    repeat (3) step();
    nx_rstn = 1'b0; step();
    check("mid_rst_req_ready", 128'(s_req_ready), 128'(0));
    check("mid_rst_resp_valid", 128'(s_resp_valid), 128'(0));
    check("mid_rst_strobe", 128'(s_strobe), 128'(0));
    check("mid_rst_err", 128'(s_resp_err), 128'(0));
    check("mid_rst_data", s_resp_data, 128'(0));
    step();
    nx_rstn = 1'b1; step();
    nx_spur = 1; step(); nx_spur = 0;
    check("stray_resp_ready", 128'(s_req_ready), 128'(1));
    check("stray_resp_valid", 128'(s_resp_valid), 128'(0));
    step();
    check("stray_idle", 128'(s_req_ready), 128'(1));
    check("stray_no_strobe", 128'(s_strobe), 128'(0));
    $display("reset in WAIT_LO with stray response");
    fetch(24'($urandom), 0, 0, 1);

    // randomized fetches
    for (int n = 0; n < 25; n++) begin
      int r;
      r = int'($urandom_range(5));
      rom_lat_max = int'($urandom_range(4));
      fetch(24'($urandom), (r == 0) ? 1 : ((r == 1) ? 2 : 0),
            int'($urandom_range(3)), int'($urandom_range(3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/boot_fetch_bridge.md
BOOT_FETCH_BRIDGE -- requirements
Module: boot_fetch_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, max cycles to wait per boot-ROM response before flagging an error.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 req_valid_i  input  1  fetch request from core: one 16-byte line.
REQ-005 req_addr_i  input  24  byte address of the fetch; bits [3:0] ignored.
REQ-006 req_ready_o  output  1  bridge accepts a request this cycle.
REQ-007 kill_i  input  1  abort the current fetch; no response is returned.
REQ-008 resp_valid_o  output  1  assembled line available.
REQ-009 resp_data_o  output  128  line: [63:0] from line offset 0, [127:64] from offset 8.
REQ-010 resp_err_o  output  1  qualifies resp_valid_o; 1 means the fetch timed out.
REQ-011 resp_ready_i  input  1  core consumes the response.
REQ-012 brom_req_address_o  output  24  boot-ROM request address.
REQ-013 brom_req_valid_o  output  1  single-cycle boot-ROM request strobe.
REQ-014 brom_ready_i  input  1  boot ROM idle and able to accept a strobe.
REQ-015 brom_resp_data_i  input  128  boot-ROM data; only [63:0] used.
REQ-016 brom_resp_valid_i  input  1  single-cycle boot-ROM response strobe.

Function
REQ-017 FSM states shall be: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, RESP, DRAIN.
REQ-018 req_ready_o shall be 1 only in IDLE; a request is accepted when req_valid_i && req_ready_o, and {req_addr_i[23:4],4'h0} is latched.
REQ-019 IDLE -> REQ_LO on accept.
REQ-020 REQ_LO shall hold brom_req_valid_o=0 until brom_ready_i=1, then assert brom_req_valid_o for exactly one cycle with address {line,4'h0}, and move to WAIT_LO.
REQ-021 WAIT_LO shall capture brom_resp_data_i[63:0] into data[63:0] on brom_resp_valid_i, then move to REQ_HI.
REQ-022 REQ_HI and WAIT_HI shall behave like REQ_LO and WAIT_LO, using address {line,4'h8} and capturing into data[127:64], then move to RESP.
REQ-023 RESP shall hold resp_valid_o=1 with stable data and error flag until resp_ready_i=1, then go to IDLE; resp_valid_o=0 in every other state.
REQ-024 brom_req_valid_o shall never be asserted in two consecutive cycles or while brom_ready_i=0.
REQ-025 brom_resp_valid_i outside WAIT_LO, WAIT_HI or DRAIN shall be ignored.
REQ-026 Timeout counter: cleared on entering WAIT_LO or WAIT_HI, incremented each cycle spent there.
REQ-027 Timeout: when the counter reaches TIMEOUT_CYCLES-1 without a response, go to RESP with resp_err_o=1 and resp_data_o=0; the counter shall be wide enough for TIMEOUT_CYCLES without wrap.
REQ-028 kill_i=1 in REQ_LO or REQ_HI shall return the FSM to IDLE without issuing a strobe; if the strobe is issued in the same cycle, go to DRAIN instead.
REQ-029 kill_i=1 in WAIT_LO or WAIT_HI shall go to DRAIN; a response arriving in that same cycle shall be discarded and the FSM shall go to IDLE.
REQ-030 kill_i=1 in RESP shall drop the response and go to IDLE; kill_i in IDLE or DRAIN shall have no effect.
REQ-031 DRAIN shall wait for brom_resp_valid_i (or timeout), discard the data, then go to IDLE; req_ready_o=0 throughout DRAIN.
REQ-032 kill_i shall take priority over resp_ready_i, response capture and timeout in the same cycle.

Reset
REQ-033 On rstn=0: FSM=IDLE, resp_valid_o=0, resp_err_o=0, brom_req_valid_o=0, timeout counter=0, data=0.
REQ-034 req_ready_o shall be forced 0 while rstn=0.
REQ-035 Reset mid-fetch shall abandon the fetch; a late brom_resp_valid_i after reset shall be ignored per REQ-025.

Verification
REQ-036 Fetch 0x000104 with ROM words 0x11..11 at line offset 0 and 0x22..22 at offset 8 -> strobes at 0x000100 then 0x000108; resp_data_o=0x2222222222222222_1111111111111111; resp_err_o=0.
REQ-037 brom_ready_i held 0 for 10 cycles after accept -> no strobe until ready rises, then exactly one strobe.
REQ-038 No ROM response, TIMEOUT_CYCLES=64 -> resp_valid_o with resp_err_o=1 and data 0 after 64 cycles in WAIT_LO.
REQ-039 kill_i in WAIT_HI, ROM responds 2 cycles later -> no resp_valid_o; req_ready_o returns to 1 the cycle after the discarded response.
REQ-040 resp_ready_i held 0 for 5 cycles in RESP -> resp_data_o stable and req_ready_o=0 throughout; IDLE after the handshake.
REQ-041 rstn pulsed low in WAIT_LO, ROM response 1 cycle after reset release -> all outputs at reset values, response ignored, next fetch completes correctly.
